// File: rtl/uart_pattern_ctrl_pkg.sv
// Shared definitions for the UART byte-stream pattern matcher: byte width and FSM states.
package uart_pattern_ctrl_pkg;
    localparam int UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_HUNT  = 2'd1,
        ST_TRACK = 2'd2
    } state_t;
endpackage

// File: rtl/uart_pattern_regfile.sv
// Pattern storage: MAX_LEN bytes, synchronous write, asynchronous read of every entry.
module uart_pattern_regfile
    import uart_pattern_ctrl_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int ADDR_W  = 3
) (
    input  logic                                    i_clk,
    input  logic                                    i_rst,
    input  logic                                    i_we,
    input  logic [ADDR_W-1:0]                       i_addr,
    input  logic [UART_BYTE_W-1:0]                  i_wdata,
    output logic [MAX_LEN-1:0][UART_BYTE_W-1:0]     o_pat
);
    logic [MAX_LEN-1:0][UART_BYTE_W-1:0] r_pat;

    // Addresses past MAX_LEN are dropped (reachable when MAX_LEN is not a power of two).
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            r_pat <= '0;
        else if (i_we && (int'(i_addr) < MAX_LEN))
            r_pat[i_addr] <= i_wdata;
    end

    assign o_pat = r_pat;
endmodule

// File: rtl/uart_pattern_ctrl.sv
// Byte-stream pattern-match controller with saturating match counter.
// Optional inter-byte timeout in TRACK is enabled by defining UART_PATTERN_TIMEOUT_EN.
module uart_pattern_ctrl
    import uart_pattern_ctrl_pkg::*;
#(
    parameter int MAX_LEN        = 8,
    parameter int CNT_W          = 16,
    parameter int TIMEOUT_CYCLES = 100000,
    localparam int ADDR_W        = $clog2(MAX_LEN),
    localparam int LEN_W         = $clog2(MAX_LEN + 1)
) (
    input  logic                   sys_clk,
    input  logic                   reset,
    input  logic [UART_BYTE_W-1:0] byte_in,
    input  logic                   byte_valid,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [UART_BYTE_W-1:0] cfg_wdata,
    input  logic [LEN_W-1:0]       cfg_len,
    input  logic                   arm,
    input  logic                   disarm,
    output logic                   armed,
    output logic                   match_pulse,
    output logic [CNT_W-1:0]       match_count,
    output logic                   timeout_pulse
);
    if (MAX_LEN < 2 || TIMEOUT_CYCLES < 2) begin : g_param_chk
        $error("uart_pattern_ctrl: MAX_LEN and TIMEOUT_CYCLES must be >= 2");
    end

    state_t                              r_state, w_state_nxt;
    logic [ADDR_W-1:0]                   r_idx, w_idx_nxt;
    logic [LEN_W-1:0]                    r_len, w_len_nxt;
    logic [CNT_W-1:0]                    r_count;
    logic                                r_match;
    logic                                w_match, w_clr_cnt, w_we, w_len_ok, w_tmo_hit;
    logic [MAX_LEN-1:0][UART_BYTE_W-1:0] w_pat;

    uart_pattern_regfile #(.MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) u_regfile (
        .i_clk   (sys_clk),
        .i_rst   (reset),
        .i_we    (w_we),
        .i_addr  (cfg_addr),
        .i_wdata (cfg_wdata),
        .o_pat   (w_pat)
    );

    assign w_len_ok = (cfg_len != '0) && (cfg_len <= LEN_W'(MAX_LEN));

    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_len_nxt   = r_len;
        w_match     = 1'b0;
        w_clr_cnt   = 1'b0;
        w_we        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_we = cfg_we;
                if (arm && !disarm && w_len_ok) begin
                    w_len_nxt   = cfg_len;
                    w_idx_nxt   = '0;
                    w_clr_cnt   = 1'b1;
                    w_state_nxt = ST_HUNT;
                end
            end
            ST_HUNT: begin
                if (disarm) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (byte_valid && byte_in == w_pat[0]) begin
                    if (r_len == LEN_W'(1)) begin
                        w_match = 1'b1;
                    end else begin
                        w_idx_nxt   = ADDR_W'(1);
                        w_state_nxt = ST_TRACK;
                    end
                end
            end
            ST_TRACK: begin
                if (disarm) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_IDLE;
                end else if (byte_valid) begin
                    if (byte_in == w_pat[r_idx]) begin
                        if (LEN_W'(r_idx) == r_len - LEN_W'(1)) begin
                            w_match     = 1'b1;
                            w_idx_nxt   = '0;
                            w_state_nxt = ST_HUNT;
                        end else begin
                            w_idx_nxt = r_idx + ADDR_W'(1);
                        end
                    // Single-step restart only: a mismatching byte may itself begin a new match.
                    end else if (byte_in == w_pat[0]) begin
                        w_idx_nxt = ADDR_W'(1);
                    end else begin
                        w_idx_nxt   = '0;
                        w_state_nxt = ST_HUNT;
                    end
                end else if (w_tmo_hit) begin
                    w_idx_nxt   = '0;
                    w_state_nxt = ST_HUNT;
                end
            end
            default: begin
                w_idx_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_len   <= '0;
            r_count <= '0;
            r_match <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_len   <= w_len_nxt;
            r_match <= w_match;
            if (w_clr_cnt)
                r_count <= '0;
            else if (w_match && r_count != '1)
                r_count <= r_count + CNT_W'(1);
        end
    end

`ifdef UART_PATTERN_TIMEOUT_EN
    localparam int TC_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TC_W-1:0] r_tcnt;
    logic            r_tmo;

    assign w_tmo_hit = (r_tcnt == TC_W'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            r_tcnt <= '0;
            r_tmo  <= 1'b0;
        end else begin
            r_tmo <= (r_state == ST_TRACK) && !disarm && !byte_valid && w_tmo_hit;
            if (r_state != ST_TRACK || byte_valid)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + TC_W'(1);
        end
    end

    assign timeout_pulse = r_tmo;
`else
    assign w_tmo_hit     = 1'b0;
    assign timeout_pulse = 1'b0;
`endif

    assign armed       = (r_state != ST_IDLE);
    assign match_pulse = r_match;
    assign match_count = r_count;
endmodule

// File: tb/tb_uart_pattern_ctrl.sv
// Self-checking bench for uart_pattern_ctrl: directed steps plus random A/B streams vs a queue-based model.
module tb_uart_pattern_ctrl;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 4;
    localparam int TMO     = 16;
    localparam int ADDR_W  = $clog2(MAX_LEN);
    localparam int LEN_W   = $clog2(MAX_LEN + 1);

    logic               sys_clk = 1'b0;
    logic               reset = 1'b1;
    logic [7:0]         byte_in = '0;
    logic               byte_valid = 1'b0;
    logic               cfg_we = 1'b0;
    logic [ADDR_W-1:0]  cfg_addr = '0;
    logic [7:0]         cfg_wdata = '0;
    logic [LEN_W-1:0]   cfg_len = '0;
    logic               arm = 1'b0;
    logic               disarm = 1'b0;
    logic               armed, match_pulse, timeout_pulse;
    logic [CNT_W-1:0]   match_count;

    uart_pattern_ctrl #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .TIMEOUT_CYCLES(TMO)) dut (
        .sys_clk(sys_clk), .reset(reset), .byte_in(byte_in), .byte_valid(byte_valid),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_len(cfg_len),
        .arm(arm), .disarm(disarm), .armed(armed), .match_pulse(match_pulse),
        .match_count(match_count), .timeout_pulse(timeout_pulse)
    );

    always #5 sys_clk = ~sys_clk;

    int n_chk = 0;
    int n_fail = 0;

    // Reference model: pattern, armed flag, bytes matched so far, match count.
    bit         m_armed = 1'b0;
    logic [7:0] m_pat [MAX_LEN];
    int         m_len = 0;
    logic [7:0] m_part [$];
    int         m_cnt = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic bit model_byte(input logic [7:0] b);
        bit ok = 1'b1;
        if (!m_armed) return 1'b0;
        m_part.push_back(b);
        foreach (m_part[i]) if (m_part[i] !== m_pat[i]) ok = 1'b0;
        if (ok) begin
            if (m_part.size() == m_len) begin
                m_part.delete();
                if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
                return 1'b1;
            end
            return 1'b0;
        end
        m_part.delete();
        if (b == m_pat[0]) m_part.push_back(b);
        return 1'b0;
    endfunction

    task automatic cyc();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #1;
        m_armed = 1'b0; m_len = 0; m_cnt = 0; m_part.delete();
        foreach (m_pat[i]) m_pat[i] = 8'h00;
        chk("rst_armed", armed, 0);
        chk("rst_match_pulse", match_pulse, 0);
        chk("rst_match_count", match_count, 0);
        chk("rst_timeout_pulse", timeout_pulse, 0);
        cyc();
        reset = 1'b0;
    endtask

    task automatic wr(input int addr, input logic [7:0] data);
        cfg_we = 1'b1; cfg_addr = ADDR_W'(addr); cfg_wdata = data;
        cyc();
        cfg_we = 1'b0;
        if (!m_armed && addr < MAX_LEN) m_pat[addr] = data;
    endtask

    task automatic do_arm(input int len, input bit dis);
        arm = 1'b1; cfg_len = LEN_W'(len); disarm = dis;
        cyc();
        arm = 1'b0; disarm = 1'b0;
        if (dis) begin
            m_armed = 1'b0; m_part.delete();
        end else if (!m_armed && len >= 1 && len <= MAX_LEN) begin
            m_armed = 1'b1; m_len = len; m_cnt = 0; m_part.delete();
        end
        chk("arm_armed", armed, m_armed);
        chk("arm_count", match_count, m_cnt);
    endtask

    task automatic do_disarm();
        disarm = 1'b1;
        cyc();
        disarm = 1'b0;
        m_armed = 1'b0; m_part.delete();
        chk("disarm_armed", armed, 0);
        chk("disarm_count", match_count, m_cnt);
    endtask

    task automatic send(input logic [7:0] b, input bit dis);
        bit exp_m;
        byte_in = b; byte_valid = 1'b1; disarm = dis;
        if (dis) begin
            m_armed = 1'b0; m_part.delete(); exp_m = 1'b0;
        end else begin
            exp_m = model_byte(b);
        end
        cyc();
        byte_valid = 1'b0; disarm = 1'b0;
        chk("match_pulse", match_pulse, exp_m);
        chk("match_count", match_count, m_cnt);
        chk("armed", armed, m_armed);
        chk("no_timeout", timeout_pulse, 0);
    endtask

    task automatic gap(input int n);
        for (int i = 0; i < n; i++) begin
            cyc();
            chk("gap_match_pulse", match_pulse, 0);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // "AB": single match
        wr(0, 8'h41); wr(1, 8'h42); do_arm(2, 1'b0);
        send(8'h41, 1'b0); send(8'h42, 1'b0);
        gap(2);
        chk("ab_count", match_count, 1);

        // "AAB": restart rule means 41,41,41,42 does not match
        do_disarm();
        wr(0, 8'h41); wr(1, 8'h41); wr(2, 8'h42); do_arm(3, 1'b0);
        send(8'h41, 1'b0); send(8'h41, 1'b0); send(8'h41, 1'b0); send(8'h42, 1'b0);
        chk("aab_nomatch_count", match_count, 0);
        send(8'h41, 1'b0); send(8'h41, 1'b0); send(8'h42, 1'b0);
        chk("aab_match_count", match_count, 1);

        // len=1 back-to-back
        do_disarm();
        wr(0, 8'h55); do_arm(1, 1'b0);
        send(8'h55, 1'b0); send(8'h55, 1'b0); send(8'h55, 1'b0);
        chk("len1_count", match_count, 3);

        // Pattern frozen while armed
        wr(0, 8'h00);
        send(8'h55, 1'b0);
        send(8'h00, 1'b0);

        // Saturation of the narrow counter
        for (int i = 0; i < 16; i++) send(8'h55, 1'b0);
        chk("sat_count", match_count, (1 << CNT_W) - 1);

        // Invalid arms
        do_disarm();
        chk("count_held", match_count, (1 << CNT_W) - 1);
        do_arm(0, 1'b0);
        do_arm(MAX_LEN + 1, 1'b0);
        do_arm(2, 1'b1);
        send(8'h55, 1'b0);

        // Random streams over a two-letter alphabet
        for (int r = 0; r < 6; r++) begin
            int len;
            len = $urandom_range(1, 4);
            for (int a = 0; a < len; a++) wr(a, ($urandom_range(0, 1) != 0) ? 8'h41 : 8'h42);
            do_arm(len, 1'b0);
            for (int k = 0; k < 50; k++) begin
                send(($urandom_range(0, 1) != 0) ? 8'h41 : 8'h42, 1'b0);
                gap($urandom_range(0, 2));
            end
            do_disarm();
        end

        // disarm together with the completing byte
        wr(0, 8'h41); wr(1, 8'h42); do_arm(2, 1'b0);
        send(8'h41, 1'b0); send(8'h41, 1'b0); send(8'h42, 1'b0);
        send(8'h41, 1'b0);
        send(8'h42, 1'b1);
        gap(1);
        chk("disarm_drop_count", match_count, 1);

        // Reset mid-TRACK clears everything including the pattern
        do_arm(2, 1'b0);
        send(8'h41, 1'b0);
        do_reset();
        do_arm(2, 1'b0);
        send(8'h41, 1'b0); send(8'h42, 1'b0);
        send(8'h00, 1'b0); send(8'h00, 1'b0);
        chk("post_reset_count", match_count, 1);

`ifdef UART_PATTERN_TIMEOUT_EN
        begin
            int seen;
            do_disarm();
            wr(0, 8'h41); wr(1, 8'h42); do_arm(2, 1'b0);
            send(8'h41, 1'b0);
            seen = 0;
            for (int i = 0; i < TMO; i++) begin
                cyc();
                if (timeout_pulse) seen++;
                chk("tmo_gap_match", match_pulse, 0);
            end
            chk("timeout_seen", seen, 1);
            m_part.delete();
            send(8'h42, 1'b0);
            send(8'h41, 1'b0);
            gap(TMO - 4);
            send(8'h42, 1'b0);
            chk("tmo_late_match_count", match_count, 1);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
